// File: rtl/main_net_weight_memory_if.sv
// Bundles the weight read-request/response and write-back signals of main_net_weight_memory.
// The slave modport is the memory; the master modport is the update engine / requester.
interface main_net_weight_memory_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int LAYER_WIDTH = 2,
  parameter int ADDR_WIDTH  = 11
);
  logic                   i_weight_valid_request;
  logic [LAYER_WIDTH-1:0] i_weight_layer_request;
  logic [ADDR_WIDTH-1:0]  i_weight_addr_request;
  logic                   o_weight_valid;
  logic [LAYER_WIDTH-1:0] o_weight_layer;
  logic [ADDR_WIDTH-1:0]  o_weight_addr;
  logic [DATA_WIDTH-1:0]  o_weight;
  logic                   i_new_weight_valid;
  logic [LAYER_WIDTH-1:0] i_new_weight_layer;
  logic [ADDR_WIDTH-1:0]  i_new_weight_addr;
  logic [DATA_WIDTH-1:0]  i_new_weight;
  logic [ADDR_WIDTH-1:0]  o_write_count;
  logic                   o_update_done;
  logic                   o_addr_error;

  modport slave (
    input  i_weight_valid_request, i_weight_layer_request, i_weight_addr_request,
    input  i_new_weight_valid, i_new_weight_layer, i_new_weight_addr, i_new_weight,
    output o_weight_valid, o_weight_layer, o_weight_addr, o_weight,
    output o_write_count, o_update_done, o_addr_error
  );

  modport master (
    output i_weight_valid_request, i_weight_layer_request, i_weight_addr_request,
    output i_new_weight_valid, i_new_weight_layer, i_new_weight_addr, i_new_weight,
    input  o_weight_valid, o_weight_layer, o_weight_addr, o_weight,
    input  o_write_count, o_update_done, o_addr_error
  );
endinterface

// File: rtl/main_net_weight_memory.sv
// Main-net weight store: three per-layer RAMs, 2-stage pipelined read responder, counted write-back.
// Optional macro WEIGHT_WRITE_FORWARD_EN forwards same-cycle and in-flight writes into read responses.
module main_net_weight_memory #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int ADDR_WIDTH                    = 11,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  main_net_weight_memory_if.slave  bus
);

  localparam int D1    = NUMBER_OF_HIDDEN_NODE_LAYER_1 * (NUMBER_OF_INPUT_NODE + 1);
  localparam int D2    = NUMBER_OF_HIDDEN_NODE_LAYER_2 * (NUMBER_OF_HIDDEN_NODE_LAYER_1 + 1);
  localparam int D3    = NUMBER_OF_OUTPUT_NODE * (NUMBER_OF_HIDDEN_NODE_LAYER_2 + 1);
  localparam int TOTAL = D1 + D2 + D3;
  localparam int A1W   = $clog2(D1);
  localparam int A2W   = $clog2(D2);
  localparam int A3W   = $clog2(D3);

  localparam logic [LAYER_WIDTH-1:0] L_H1  = LAYER_WIDTH'(1);
  localparam logic [LAYER_WIDTH-1:0] L_H2  = LAYER_WIDTH'(2);
  localparam logic [LAYER_WIDTH-1:0] L_OUT = LAYER_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0]  D1_A  = ADDR_WIDTH'(D1);
  localparam logic [ADDR_WIDTH-1:0]  D2_A  = ADDR_WIDTH'(D2);
  localparam logic [ADDR_WIDTH-1:0]  D3_A  = ADDR_WIDTH'(D3);
  localparam logic [ADDR_WIDTH-1:0]  LAST_A = ADDR_WIDTH'(TOTAL - 1);

  function automatic logic f_in_range(input logic [LAYER_WIDTH-1:0] layer,
                                      input logic [ADDR_WIDTH-1:0]  addr);
    logic ok;
    ok = 1'b0;
    case (layer)
      L_H1:    ok = (addr < D1_A);
      L_H2:    ok = (addr < D2_A);
      L_OUT:   ok = (addr < D3_A);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic                   w_rd_ok;
  logic                   w_wr_in_range;
  logic                   w_wr_ok;
  logic                   w_wr_bad;
  logic [DATA_WIDTH-1:0]  w_ram_p1;
  logic [DATA_WIDTH-1:0]  w_rdata_p1;

  logic [DATA_WIDTH-1:0]  r_ram1 [D1];
  logic [DATA_WIDTH-1:0]  r_ram2 [D2];
  logic [DATA_WIDTH-1:0]  r_ram3 [D3];

  logic                   r_vld_p1;
  logic                   r_ok_p1;
  logic [LAYER_WIDTH-1:0] r_layer_p1;
  logic [ADDR_WIDTH-1:0]  r_addr_p1;
  logic [DATA_WIDTH-1:0]  r_rd1_p1;
  logic [DATA_WIDTH-1:0]  r_rd2_p1;
  logic [DATA_WIDTH-1:0]  r_rd3_p1;

  logic                   r_vld_p2;
  logic [LAYER_WIDTH-1:0] r_layer_p2;
  logic [ADDR_WIDTH-1:0]  r_addr_p2;
  logic [DATA_WIDTH-1:0]  r_weight_p2;
  logic                   r_addr_error;
  logic [ADDR_WIDTH-1:0]  r_write_count;
  logic                   r_update_done;

  assign w_rd_ok       = f_in_range(bus.i_weight_layer_request, bus.i_weight_addr_request);
  assign w_wr_in_range = f_in_range(bus.i_new_weight_layer, bus.i_new_weight_addr);
  assign w_wr_ok       = bus.i_new_weight_valid & w_wr_in_range;
  assign w_wr_bad      = bus.i_new_weight_valid & ~w_wr_in_range;

  // Write port: one RAM per layer, written on the sampling edge
  always_ff @(posedge clk) begin
    if (w_wr_ok && (bus.i_new_weight_layer == L_H1))
      r_ram1[bus.i_new_weight_addr[A1W-1:0]] <= bus.i_new_weight;
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok && (bus.i_new_weight_layer == L_H2))
      r_ram2[bus.i_new_weight_addr[A2W-1:0]] <= bus.i_new_weight;
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok && (bus.i_new_weight_layer == L_OUT))
      r_ram3[bus.i_new_weight_addr[A3W-1:0]] <= bus.i_new_weight;
  end

  // Stage p0 -> p1: register request and range check, read all three RAMs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_vld_p1 <= 1'b0;
    else        r_vld_p1 <= bus.i_weight_valid_request;
  end

  always_ff @(posedge clk) begin
    r_ok_p1    <= w_rd_ok;
    r_layer_p1 <= bus.i_weight_layer_request;
    r_addr_p1  <= bus.i_weight_addr_request;
    r_rd1_p1   <= r_ram1[bus.i_weight_addr_request[A1W-1:0]];
    r_rd2_p1   <= r_ram2[bus.i_weight_addr_request[A2W-1:0]];
    r_rd3_p1   <= r_ram3[bus.i_weight_addr_request[A3W-1:0]];
  end

`ifdef WEIGHT_WRITE_FORWARD_EN
  logic                  w_hit_p0;
  logic                  w_hit_p1;
  logic                  r_fwd_p1;
  logic [DATA_WIDTH-1:0] r_fwd_data_p1;

  assign w_hit_p0 = w_wr_ok &&
                    (bus.i_new_weight_layer == bus.i_weight_layer_request) &&
                    (bus.i_new_weight_addr  == bus.i_weight_addr_request);
  assign w_hit_p1 = w_wr_ok &&
                    (bus.i_new_weight_layer == r_layer_p1) &&
                    (bus.i_new_weight_addr  == r_addr_p1);

  always_ff @(posedge clk) begin
    r_fwd_p1      <= w_hit_p0;
    r_fwd_data_p1 <= bus.i_new_weight;
  end
`endif

  // A write arriving while the request sits in p1 is newer than any same-cycle hit
  always_comb begin
    w_ram_p1 = '0;
    case (r_layer_p1)
      L_H1:    w_ram_p1 = r_rd1_p1;
      L_H2:    w_ram_p1 = r_rd2_p1;
      L_OUT:   w_ram_p1 = r_rd3_p1;
      default: w_ram_p1 = '0;
    endcase
`ifdef WEIGHT_WRITE_FORWARD_EN
    if (r_fwd_p1) w_ram_p1 = r_fwd_data_p1;
    if (w_hit_p1) w_ram_p1 = bus.i_new_weight;
`endif
    w_rdata_p1 = r_ok_p1 ? w_ram_p1 : '0;
  end

  // Stage p1 -> p2: registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2    <= 1'b0;
      r_layer_p2  <= '0;
      r_addr_p2   <= '0;
      r_weight_p2 <= '0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_layer_p2  <= r_layer_p1;
        r_addr_p2   <= r_addr_p1;
        r_weight_p2 <= w_rdata_p1;
      end
    end
  end

  // Read errors surface with their response, write errors one cycle after the write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_addr_error <= 1'b0;
    else        r_addr_error <= (r_vld_p1 & ~r_ok_p1) | w_wr_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_write_count <= '0;
      r_update_done <= 1'b0;
    end else begin
      r_update_done <= 1'b0;
      if (w_wr_ok) begin
        if (r_write_count == LAST_A) begin
          r_write_count <= '0;
          r_update_done <= 1'b1;
        end else begin
          r_write_count <= r_write_count + 1'b1;
        end
      end
    end
  end

  assign bus.o_weight_valid = r_vld_p2;
  assign bus.o_weight_layer = r_layer_p2;
  assign bus.o_weight_addr  = r_addr_p2;
  assign bus.o_weight       = r_weight_p2;
  assign bus.o_addr_error   = r_addr_error;
  assign bus.o_write_count  = r_write_count;
  assign bus.o_update_done  = r_update_done;

endmodule

// File: tb/tb_main_net_weight_memory.sv
// Randomised scoreboard bench for main_net_weight_memory against a flat per-layer memory model.
module tb_main_net_weight_memory;
  localparam int DW = 32, LW = 2, AW = 11;
  localparam int D1 = 96, D2 = 1056, D3 = 99, TOTAL = 1251;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  main_net_weight_memory_if #(.DATA_WIDTH(DW), .LAYER_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

  main_net_weight_memory #(
    .DATA_WIDTH(DW), .LAYER_WIDTH(LW), .ADDR_WIDTH(AW),
    .NUMBER_OF_INPUT_NODE(2), .NUMBER_OF_HIDDEN_NODE_LAYER_1(32),
    .NUMBER_OF_HIDDEN_NODE_LAYER_2(32), .NUMBER_OF_OUTPUT_NODE(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    int          cyc;
    logic [1:0]  layer;
    logic [10:0] addr;
    logic [31:0] data;
    bit          err;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  bit          err_at[int];
  bit          done_at[int];
  int          cnt_at[int];
  logic [31:0] mem [4][1056];
  int          m_cnt = 0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int depth(input logic [1:0] l);
    case (l)
      2'd1:    return D1;
      2'd2:    return D2;
      2'd3:    return D3;
      default: return 0;
    endcase
  endfunction

  function automatic bit inr(input logic [1:0] l, input logic [10:0] a);
    return int'(a) < depth(l);
  endfunction

  function automatic logic [10:0] pick(input logic [1:0] l);
    if (depth(l) == 0 || $urandom_range(0, 9) == 0) return 11'($urandom_range(0, 2047));
    return 11'($urandom_range(0, depth(l) - 1));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock of stimulus; the model decides every expected outcome at issue time
  task automatic step(input bit rv, input logic [1:0] rl, input logic [10:0] ra,
                      input bit wv, input logic [1:0] wl, input logic [10:0] wa,
                      input logic [31:0] wd);
    int   c;
    exp_t e;
    @(posedge clk);
    #1;
    c = cyc;
    bus.i_weight_valid_request = rv;
    bus.i_weight_layer_request = rl;
    bus.i_weight_addr_request  = ra;
    bus.i_new_weight_valid     = wv;
    bus.i_new_weight_layer     = wl;
    bus.i_new_weight_addr      = wa;
    bus.i_new_weight           = wd;
    if (rv) begin
      e.cyc = c + 2; e.layer = rl; e.addr = ra;
      e.err = !inr(rl, ra);
      e.data = e.err ? 32'h0 : mem[rl][ra];
      sb.push_back(e);
      if (e.err) err_at[c + 2] = 1'b1;
    end
    if (wv) begin
      if (inr(wl, wa)) begin
`ifdef WEIGHT_WRITE_FORWARD_EN
        foreach (sb[i])
          if ((sb[i].cyc == c + 2 || sb[i].cyc == c + 1) && !sb[i].err &&
              sb[i].layer == wl && sb[i].addr == wa)
            sb[i].data = wd;
`endif
        mem[wl][wa] = wd;
        if (m_cnt == TOTAL - 1) begin
          m_cnt = 0;
          done_at[c + 1] = 1'b1;
        end else begin
          m_cnt++;
        end
        cnt_at[c + 1] = m_cnt;
      end else begin
        err_at[c + 1] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 11'd0, 1'b0, 2'd0, 11'd0, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.i_weight_valid_request = 1'b0;
    bus.i_new_weight_valid     = 1'b0;
    sb.delete(); err_at.delete(); done_at.delete(); cnt_at.delete();
    m_cnt = 0;
    repeat (2) @(negedge clk);
    chk("reset_write_count", 64'(bus.o_write_count), 64'(0));
    chk("reset_valid", 64'(bus.o_weight_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      if (bus.o_weight_valid !== 1'b0) begin
        tests++; fails++;
        $display("FAIL valid_in_reset: got %b expected 0", bus.o_weight_valid);
      end
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        tests++; fails++;
        $display("FAIL missing_rsp: got none expected response due cyc %0d", sb[0].cyc);
        void'(sb.pop_front());
      end
      if (bus.o_weight_valid !== 1'b0) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_rsp @cyc %0d: got valid %b expected none", cyc, bus.o_weight_valid);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("rsp_layer", 64'(bus.o_weight_layer), 64'(mon_e.layer));
          chk("rsp_addr", 64'(bus.o_weight_addr), 64'(mon_e.addr));
          chk("rsp_weight", 64'(bus.o_weight), 64'(mon_e.data));
        end
      end
      if (err_at.exists(cyc) || bus.o_addr_error !== 1'b0)
        chk("addr_error", 64'(bus.o_addr_error), 64'(err_at.exists(cyc)));
      if (done_at.exists(cyc) || bus.o_update_done !== 1'b0)
        chk("update_done", 64'(bus.o_update_done), 64'(done_at.exists(cyc)));
      if (cnt_at.exists(cyc))
        chk("write_count", 64'(bus.o_write_count), 64'(cnt_at[cyc]));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rv, wv;
    logic [1:0]  rl, wl, pl;
    logic [10:0] ra, wa, pa;
    bus.i_weight_valid_request = 1'b0;
    bus.i_weight_layer_request = '0;
    bus.i_weight_addr_request  = '0;
    bus.i_new_weight_valid     = 1'b0;
    bus.i_new_weight_layer     = '0;
    bus.i_new_weight_addr      = '0;
    bus.i_new_weight           = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_o_weight_valid", 64'(bus.o_weight_valid), 64'(0));
    chk("rst_o_weight", 64'(bus.o_weight), 64'(0));
    chk("rst_o_weight_layer", 64'(bus.o_weight_layer), 64'(0));
    chk("rst_o_weight_addr", 64'(bus.o_weight_addr), 64'(0));
    chk("rst_o_write_count", 64'(bus.o_write_count), 64'(0));
    chk("rst_o_update_done", 64'(bus.o_update_done), 64'(0));
    chk("rst_o_addr_error", 64'(bus.o_addr_error), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Preload, then single read with latency checked by the scoreboard
    step(0, 2'd0, 11'd0, 1, 2'd3, 11'd5, 32'h3F800000);
    step(0, 2'd0, 11'd0, 1, 2'd1, 11'd0, $urandom);
    step(0, 2'd0, 11'd0, 1, 2'd2, 11'd1055, $urandom);
    step(0, 2'd0, 11'd0, 1, 2'd3, 11'd98, $urandom);
    idle(2);
    step(1, 2'd3, 11'd5, 0, 2'd0, 11'd0, 32'd0);
    idle(3);

    // Back-to-back boundary reads
    step(1, 2'd1, 11'd0, 0, 2'd0, 11'd0, 32'd0);
    step(1, 2'd2, 11'd1055, 0, 2'd0, 11'd0, 32'd0);
    step(1, 2'd3, 11'd98, 0, 2'd0, 11'd0, 32'd0);
    idle(3);

    // Invalid accesses
    step(1, 2'd1, 11'd96, 0, 2'd0, 11'd0, 32'd0);
    step(1, 2'd0, 11'd3, 0, 2'd0, 11'd0, 32'd0);
    step(0, 2'd0, 11'd0, 1, 2'd2, 11'd1056, 32'h12345678);
    idle(3);
    chk("count_after_bad_write", 64'(bus.o_write_count), 64'(m_cnt));

    // Full set of writes from a cleared counter
    do_reset();
    for (int l = 1; l <= 3; l++)
      for (int a = 0; a < depth(2'(l)); a++)
        step(0, 2'd0, 11'd0, 1, 2'(l), 11'(a), $urandom);
    idle(3);
    chk("count_wrapped", 64'(bus.o_write_count), 64'(0));

    for (int i = 0; i < 100; i++) begin
      rl = 2'($urandom_range(1, 3));
      step(1, rl, 11'($urandom_range(0, depth(rl) - 1)), 0, 2'd0, 11'd0, 32'd0);
    end
    idle(3);

    // Same-cycle and next-cycle collisions on one address
    step(0, 2'd0, 11'd0, 1, 2'd2, 11'd7, 32'h3F000000);
    idle(1);
    step(1, 2'd2, 11'd7, 1, 2'd2, 11'd7, 32'h40000000);
    idle(2);
    step(1, 2'd2, 11'd7, 0, 2'd0, 11'd0, 32'd0);
    step(0, 2'd0, 11'd0, 1, 2'd2, 11'd7, 32'h41000000);
    idle(3);

    // Random concurrent traffic
    pl = 2'd1; pa = 11'd0;
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rl = 2'($urandom_range(0, 3));
      ra = pick(rl);
      wv = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       begin wl = rl; wa = ra; end
        1:       begin wl = pl; wa = pa; end
        default: begin wl = 2'($urandom_range(0, 3)); wa = pick(wl); end
      endcase
      step(rv, rl, ra, wv, wl, wa, $urandom);
      pl = rl; pa = ra;
    end
    idle(3);

    // Reset one cycle after a request drops its response but keeps RAM
    step(0, 2'd0, 11'd0, 1, 2'd1, 11'd10, 32'hDEADBEEF);
    idle(1);
    step(1, 2'd1, 11'd10, 0, 2'd0, 11'd0, 32'd0);
    do_reset();
    step(1, 2'd1, 11'd10, 0, 2'd0, 11'd0, 32'd0);
    step(1, 2'd2, 11'd7, 0, 2'd0, 11'd0, 32'd0);
    idle(3);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/main_net_weight_memory.md
Name: main_net_weight_memory

Overview:
- Weight store and responder for the main-network weight-update engine.
- Answers weight read requests (layer, addr) with the stored weight after a fixed 2-cycle latency, fully pipelined.
- Accepts the engine's new-weight write-back stream into three per-layer RAMs and signals when a full set of weights has been written.
- Sits between the update engine and the forward-pass datapath; it holds the only copy of the main-net weights.

Parameters:
- DATA_WIDTH, 32, weight word width (IEEE-754 single).
- LAYER_WIDTH, 2, layer code width (01 hidden 1, 10 hidden 2, 11 output; 00 invalid).
- ADDR_WIDTH, 11, weight address width.
- NUMBER_OF_INPUT_NODE, 2, network inputs.
- NUMBER_OF_HIDDEN_NODE_LAYER_1, 32, hidden layer 1 nodes.
- NUMBER_OF_HIDDEN_NODE_LAYER_2, 32, hidden layer 2 nodes.
- NUMBER_OF_OUTPUT_NODE, 3, output nodes.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_weight_valid_request  in  1  read request strobe.
- i_weight_layer_request  in  LAYER_WIDTH  requested layer.
- i_weight_addr_request  in  ADDR_WIDTH  requested address.
- o_weight_valid  out  1  read response strobe.
- o_weight_layer  out  LAYER_WIDTH  echoed layer.
- o_weight_addr  out  ADDR_WIDTH  echoed address.
- o_weight  out  DATA_WIDTH  weight data.
- i_new_weight_valid  in  1  write strobe.
- i_new_weight_layer  in  LAYER_WIDTH  write layer.
- i_new_weight_addr  in  ADDR_WIDTH  write address.
- i_new_weight  in  DATA_WIDTH  write data.
- o_write_count  out  ADDR_WIDTH  accepted writes in the current set.
- o_update_done  out  1  one-cycle pulse when a full set has been written.
- o_addr_error  out  1  one-cycle pulse on an invalid layer or out-of-range access.

Behaviour:
- Depths:
  - D1 = H1*(IN+1) = 96.
  - D2 = H2*(H1+1) = 1056.
  - D3 = OUT*(H2+1) = 99.
  - TOTAL = D1+D2+D3 = 1251.
- Storage: three RAMs, one write port and one read port each. RAM contents are not reset.
- Reset: all outputs are 0, the pipeline valids are cleared, and the write counter is 0. Reset asserted mid-operation drops in-flight responses: no o_weight_valid is produced for requests already accepted.
- Read pipeline:
  - Request sampled at edge N.
  - Stage 1 registers layer, addr and the range check, and reads the RAM.
  - Stage 2 registers the outputs.
  - o_weight_valid is high in cycle N+2 for exactly one cycle per request. Back-to-back requests give back-to-back responses.
  - There is no backpressure: the requester must accept every response.
  - o_weight_layer and o_weight_addr echo the request.
- Range check: the access is invalid if the layer is 00, or addr >= D1, D2 or D3 for layer 01, 10 or 11 respectively.
  - Invalid read: the response is still issued with o_weight = 0, and o_addr_error pulses in the same cycle as o_weight_valid.
- Write path:
  - A valid in-range write updates the RAM at the edge on which it is sampled.
  - An invalid write is dropped, is not counted, and pulses o_addr_error one cycle later.
  - If a read error and a write error coincide in the same cycle, they OR into a single pulse.
- Write counter:
  - Each accepted write increments o_write_count.
  - On the write taken at count TOTAL-1, the counter wraps to 0 and o_update_done pulses high in the following cycle.
  - Duplicate addresses are counted; there is no per-address tracking.
- Simultaneous read and write to the same layer/addr in the same cycle: the read returns the old data (read-before-write), unless the optional feature is enabled.
- Reads and writes to different addresses proceed concurrently with no stalls.

Optional Feature:
- Macro WEIGHT_WRITE_FORWARD_EN.
- Defined: a same-cycle read and write hit on the same layer/addr returns the new write data in the response. A write landing on the same layer/addr during the cycle between request and response is also forwarded, so responses always reflect the most recent write.
- Undefined: no forwarding and no extra compare logic; read-before-write as above.

Test Plan:
- Reset, then preload layer 11 addr 5 = 0x3F800000; request (11,5) at cycle 10 -> o_weight_valid only at cycle 12, with o_weight 0x3F800000, layer 11, addr 5.
- Requests (01,0), (10,1055), (11,98) in three consecutive cycles -> three consecutive responses, in order, with correct data; o_addr_error stays 0.
- Request (01,96), then request (00,3) -> both responses carry o_weight = 0 and o_addr_error pulses with each; a write to (10,1056) is dropped and o_write_count is unchanged.
- Stream 1251 writes (layer 01 addr 0..95, layer 10 addr 0..1055, layer 11 addr 0..98) -> o_write_count reaches 1250, o_update_done pulses one cycle after the last write, and the counter returns to 0; read-back of random addresses matches the written data.
- Same cycle: write (10,7) = 0x40000000 over old 0x3F000000 and request (10,7) -> response is 0x3F000000; with WEIGHT_WRITE_FORWARD_EN defined, the response is 0x40000000.
- Assert rst_n low one cycle after a request -> no response appears, o_write_count is 0, and RAM data written before the reset reads back unchanged.
